// File: rtl/branch_resolution_unit_if.sv
// Branch resolution bus: brinfo from the ALUs in, brupdate and redirect out.
// master = execution/frontend side, slave = branch_resolution_unit.
interface branch_resolution_unit_if #(
   parameter int NUM_BR_PORTS = 2,
   parameter int MAX_BR_COUNT = 20
);
   localparam int TW = $clog2(MAX_BR_COUNT);

   logic                                 flush;
   logic [6:0]                           rob_head_idx;
   logic [NUM_BR_PORTS-1:0]              brinfo_valid;
   logic [NUM_BR_PORTS-1:0]              brinfo_mispredict;
   logic [NUM_BR_PORTS-1:0]              brinfo_taken;
   logic [NUM_BR_PORTS-1:0][2:0]         brinfo_cfi_type;
   logic [NUM_BR_PORTS-1:0][1:0]         brinfo_pc_sel;
   logic [NUM_BR_PORTS-1:0][20:0]        brinfo_target_offset;
   logic [NUM_BR_PORTS-1:0][6:0]         brinfo_rob_idx;
   logic [NUM_BR_PORTS-1:0][TW-1:0]      brinfo_br_tag;
   logic [NUM_BR_PORTS-1:0][MAX_BR_COUNT-1:0] brinfo_br_mask;

   logic [MAX_BR_COUNT-1:0]              brupdate_b1_resolve_mask;
   logic [MAX_BR_COUNT-1:0]              brupdate_b1_mispredict_mask;
   logic                                 brupdate_b2_mispredict;
   logic [6:0]                           brupdate_b2_rob_idx;
   logic [TW-1:0]                        brupdate_b2_br_tag;
   logic [2:0]                           brupdate_b2_cfi_type;
   logic                                 brupdate_b2_taken;
   logic [1:0]                           brupdate_b2_pc_sel;
   logic [20:0]                          brupdate_b2_target_offset;

   logic                                 redirect_valid;
   logic                                 redirect_ready;
   logic [6:0]                           redirect_rob_idx;
   logic [20:0]                          redirect_target_offset;
   logic [1:0]                           redirect_pc_sel;
   logic [2:0]                           redirect_cfi_type;
   logic [15:0]                          mispredict_count;

   modport master (
      output flush, rob_head_idx,
      output brinfo_valid, brinfo_mispredict, brinfo_taken,
      output brinfo_cfi_type, brinfo_pc_sel, brinfo_target_offset,
      output brinfo_rob_idx, brinfo_br_tag, brinfo_br_mask,
      output redirect_ready,
      input  brupdate_b1_resolve_mask, brupdate_b1_mispredict_mask,
      input  brupdate_b2_mispredict, brupdate_b2_rob_idx,
      input  brupdate_b2_br_tag, brupdate_b2_cfi_type,
      input  brupdate_b2_taken, brupdate_b2_pc_sel,
      input  brupdate_b2_target_offset,
      input  redirect_valid, redirect_rob_idx, redirect_target_offset,
      input  redirect_pc_sel, redirect_cfi_type, mispredict_count
   );

   modport slave (
      input  flush, rob_head_idx,
      input  brinfo_valid, brinfo_mispredict, brinfo_taken,
      input  brinfo_cfi_type, brinfo_pc_sel, brinfo_target_offset,
      input  brinfo_rob_idx, brinfo_br_tag, brinfo_br_mask,
      input  redirect_ready,
      output brupdate_b1_resolve_mask, brupdate_b1_mispredict_mask,
      output brupdate_b2_mispredict, brupdate_b2_rob_idx,
      output brupdate_b2_br_tag, brupdate_b2_cfi_type,
      output brupdate_b2_taken, brupdate_b2_pc_sel,
      output brupdate_b2_target_offset,
      output redirect_valid, redirect_rob_idx, redirect_target_offset,
      output redirect_pc_sel, redirect_cfi_type, mispredict_count
   );
endinterface

// File: rtl/branch_resolution_unit.sv
// Branch resolution: kill filter, oldest-mispredict select, 2-stage brupdate,
// redirect hold FSM. Ports: clock, reset (async, active-low), io (slave bus).
module branch_resolution_unit #(
   parameter int NUM_BR_PORTS    = 2,
   parameter int MAX_BR_COUNT    = 20,
   parameter int NUM_ROB_ENTRIES = 96
) (
   input logic clock,
   input logic reset,
   branch_resolution_unit_if.slave io
);
   localparam int TW = $clog2(MAX_BR_COUNT);
   localparam int PW = (NUM_BR_PORTS > 1) ? $clog2(NUM_BR_PORTS) : 1;

   typedef logic [MAX_BR_COUNT-1:0] mask_t;
   typedef enum logic {IDLE, PENDING} state_t;

   typedef struct packed {
      logic [6:0]    rob;
      logic [TW-1:0] tag;
      logic [2:0]    cfi;
      logic          taken;
      logic [1:0]    pc_sel;
      logic [20:0]   off;
   } br_t;

   typedef struct packed {
      logic [6:0]  rob;
      logic [2:0]  cfi;
      logic [1:0]  pc_sel;
      logic [20:0] off;
   } rd_t;

   // ROB index distance from head; rob_idx wraps at NUM_ROB_ENTRIES.
   function automatic logic [6:0] age(input logic [6:0] x,
                                      input logic [6:0] h);
      logic [7:0] a;
      if (x >= h) a = {1'b0, x} - {1'b0, h};
      else        a = {1'b0, x} + 8'(NUM_ROB_ENTRIES) - {1'b0, h};
      return a[6:0];
   endfunction

   function automatic mask_t onehot(input logic [TW-1:0] t);
      return mask_t'(1) << t;
   endfunction

   mask_t            b1_res_q, b1_mp_q;
   br_t              s1_q, b2_q;
   logic             b2_v_q;
   mask_t            res_d, mp_d;
   br_t              s1_d;
   logic             win_v;
   logic [PW-1:0]    win;

   always_comb begin
      mask_t others;
      logic  alive;
      res_d = '0;
      mp_d  = '0;
      s1_d  = '0;
      win_v = 1'b0;
      win   = '0;
      for (int i = 0; i < NUM_BR_PORTS; i++) begin
         // tags of other ports mispredicting this very cycle
         others = '0;
         for (int j = 0; j < NUM_BR_PORTS; j++)
            if (j != i && io.brinfo_valid[j] && io.brinfo_mispredict[j])
               others |= onehot(io.brinfo_br_tag[j]);
         alive = !io.flush && io.brinfo_valid[i] &&
                 ((io.brinfo_br_mask[i] & (b1_mp_q | others)) == '0);
         if (alive) res_d |= onehot(io.brinfo_br_tag[i]);
         // strict < keeps the lower port on equal age
         if (alive && io.brinfo_mispredict[i] &&
             (!win_v || age(io.brinfo_rob_idx[i], io.rob_head_idx) <
                        age(io.brinfo_rob_idx[win], io.rob_head_idx))) begin
            win_v = 1'b1;
            win   = PW'(i);
         end
      end
      if (win_v) begin
         mp_d = onehot(io.brinfo_br_tag[win]);
         s1_d = '{rob:    io.brinfo_rob_idx[win],
                  tag:    io.brinfo_br_tag[win],
                  cfi:    io.brinfo_cfi_type[win],
                  taken:  io.brinfo_taken[win],
                  pc_sel: io.brinfo_pc_sel[win],
                  off:    io.brinfo_target_offset[win]};
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         b1_res_q <= '0;
         b1_mp_q  <= '0;
         s1_q     <= '0;
         b2_v_q   <= 1'b0;
         b2_q     <= '0;
      end else if (io.flush) begin
         b1_res_q <= '0;
         b1_mp_q  <= '0;
         s1_q     <= '0;
         b2_v_q   <= 1'b0;
         b2_q     <= '0;
      end else begin
         b1_res_q <= res_d;
         b1_mp_q  <= mp_d;
         s1_q     <= s1_d;
         b2_v_q   <= (b1_mp_q != '0);
         b2_q     <= s1_q;
      end
   end

   state_t      state;
   rd_t         pend;
   rd_t         b2_rd;
   logic        rv;
   logic [15:0] cnt;
   logic        older;

   assign b2_rd = '{rob: b2_q.rob, cfi: b2_q.cfi,
                    pc_sel: b2_q.pc_sel, off: b2_q.off};
   assign older = b2_v_q &&
                  (age(b2_q.rob, io.rob_head_idx) <
                   age(pend.rob, io.rob_head_idx));

   // count survives flush; flush masks ready so nothing is counted
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         pend  <= '0;
         rv    <= 1'b0;
         cnt   <= '0;
      end else if (io.flush) begin
         state <= IDLE;
         pend  <= '0;
         rv    <= 1'b0;
      end else begin
         unique case (state)
            IDLE: if (b2_v_q) begin
               state <= PENDING;
               pend  <= b2_rd;
               rv    <= 1'b1;
            end
            PENDING: if (io.redirect_ready) begin
               cnt <= cnt + 16'd1;
               if (older) begin
                  pend <= b2_rd;
               end else begin
                  state <= IDLE;
                  pend  <= '0;
                  rv    <= 1'b0;
               end
            end else if (older) begin
               pend <= b2_rd;
            end
         endcase
      end
   end

   assign io.brupdate_b1_resolve_mask    = b1_res_q;
   assign io.brupdate_b1_mispredict_mask = b1_mp_q;
   assign io.brupdate_b2_mispredict      = b2_v_q;
   assign io.brupdate_b2_rob_idx         = b2_q.rob;
   assign io.brupdate_b2_br_tag          = b2_q.tag;
   assign io.brupdate_b2_cfi_type        = b2_q.cfi;
   assign io.brupdate_b2_taken           = b2_q.taken;
   assign io.brupdate_b2_pc_sel          = b2_q.pc_sel;
   assign io.brupdate_b2_target_offset   = b2_q.off;
   assign io.redirect_valid              = rv;
   assign io.redirect_rob_idx            = pend.rob;
   assign io.redirect_target_offset      = pend.off;
   assign io.redirect_pc_sel             = pend.pc_sel;
   assign io.redirect_cfi_type           = pend.cfi;
   assign io.mispredict_count            = cnt;
endmodule

// File: tb/tb_branch_resolution_unit.sv
// Self-checking bench for branch_resolution_unit.
// Stage-1 results go through a scoreboard queue; redirect checked inline.
module tb_branch_resolution_unit;
   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   branch_resolution_unit_if bus ();
   branch_resolution_unit dut (.clock(clock), .reset(reset), .io(bus));

   typedef struct packed {
      logic [19:0] res;
      logic [19:0] mp;
   } b1_exp_t;

   b1_exp_t sb[$];
   b1_exp_t e;
   int total = 0;
   int bad = 0;
   int exp_count = 0;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      bus.flush                = 1'b0;
      bus.brinfo_valid         = '0;
      bus.brinfo_mispredict    = '0;
      bus.brinfo_taken         = '0;
      bus.brinfo_cfi_type      = '0;
      bus.brinfo_pc_sel        = '0;
      bus.brinfo_target_offset = '0;
      bus.brinfo_rob_idx       = '0;
      bus.brinfo_br_tag        = '0;
      bus.brinfo_br_mask       = '0;
   endtask

   task automatic drv(input int p, input logic mp, input int tag,
                      input int rob, input logic [19:0] m,
                      input logic [20:0] off);
      bus.brinfo_valid[p]         = 1'b1;
      bus.brinfo_mispredict[p]    = mp;
      bus.brinfo_taken[p]         = mp;
      bus.brinfo_cfi_type[p]      = 3'(p + 1);
      bus.brinfo_pc_sel[p]        = 2'd1;
      bus.brinfo_target_offset[p] = off;
      bus.brinfo_rob_idx[p]       = 7'(rob);
      bus.brinfo_br_tag[p]        = 5'(tag);
      bus.brinfo_br_mask[p]       = m;
   endtask

   task automatic test_reset();
      idle();
      bus.rob_head_idx   = '0;
      bus.redirect_ready = 1'b0;
      #12;
      total++; if (bus.brupdate_b1_resolve_mask !== 20'h0) begin bad++; $display("FAIL rst_res got=%h want=0", bus.brupdate_b1_resolve_mask); end
      total++; if (bus.brupdate_b1_mispredict_mask !== 20'h0) begin bad++; $display("FAIL rst_mp got=%h want=0", bus.brupdate_b1_mispredict_mask); end
      total++; if (bus.brupdate_b2_mispredict !== 1'b0) begin bad++; $display("FAIL rst_b2 got=%b want=0", bus.brupdate_b2_mispredict); end
      total++; if (bus.redirect_valid !== 1'b0) begin bad++; $display("FAIL rst_rv got=%b want=0", bus.redirect_valid); end
      total++; if (bus.mispredict_count !== 16'd0) begin bad++; $display("FAIL rst_cnt got=%0d want=0", bus.mispredict_count); end
      @(negedge clock);
      reset = 1'b1;
      tick();
   endtask

   task automatic test_resolve();
      bus.rob_head_idx = 7'd0;
      idle();
      drv(0, 1'b0, 3, 5, 20'h0, 21'h0);
      sb.push_back('{res: 20'h00008, mp: 20'h0});
      tick();
      idle();
      e = sb.pop_front();
      total++; if (bus.brupdate_b1_resolve_mask !== e.res) begin bad++; $display("FAIL resolve_res got=%h want=%h", bus.brupdate_b1_resolve_mask, e.res); end
      total++; if (bus.brupdate_b1_mispredict_mask !== e.mp) begin bad++; $display("FAIL resolve_mp got=%h want=%h", bus.brupdate_b1_mispredict_mask, e.mp); end
      tick();
      total++; if (bus.brupdate_b2_mispredict !== 1'b0) begin bad++; $display("FAIL resolve_b2 got=%b want=0", bus.brupdate_b2_mispredict); end
      tick();
      total++; if (bus.redirect_valid !== 1'b0) begin bad++; $display("FAIL resolve_rv got=%b want=0", bus.redirect_valid); end
   endtask

   task automatic test_oldest();
      bus.rob_head_idx = 7'd10;
      idle();
      drv(0, 1'b1, 1, 20, 20'h0, 21'h111);
      drv(1, 1'b1, 2, 15, 20'h0, 21'h222);
      sb.push_back('{res: 20'h00006, mp: 20'h00004});
      tick();
      idle();
      e = sb.pop_front();
      total++; if (bus.brupdate_b1_resolve_mask !== e.res) begin bad++; $display("FAIL oldest_res got=%h want=%h", bus.brupdate_b1_resolve_mask, e.res); end
      total++; if (bus.brupdate_b1_mispredict_mask !== e.mp) begin bad++; $display("FAIL oldest_mp got=%h want=%h", bus.brupdate_b1_mispredict_mask, e.mp); end
      tick();
      total++; if (bus.brupdate_b2_mispredict !== 1'b1) begin bad++; $display("FAIL oldest_b2 got=%b want=1", bus.brupdate_b2_mispredict); end
      total++; if (bus.brupdate_b2_rob_idx !== 7'd15) begin bad++; $display("FAIL oldest_b2rob got=%0d want=15", bus.brupdate_b2_rob_idx); end
      total++; if (bus.brupdate_b2_br_tag !== 5'd2) begin bad++; $display("FAIL oldest_b2tag got=%0d want=2", bus.brupdate_b2_br_tag); end
      total++; if (bus.brupdate_b2_target_offset !== 21'h222) begin bad++; $display("FAIL oldest_b2off got=%h want=222", bus.brupdate_b2_target_offset); end
      tick();
      total++; if (bus.redirect_valid !== 1'b1) begin bad++; $display("FAIL oldest_rv got=%b want=1", bus.redirect_valid); end
      total++; if (bus.redirect_rob_idx !== 7'd15) begin bad++; $display("FAIL oldest_rdrob got=%0d want=15", bus.redirect_rob_idx); end
      bus.redirect_ready = 1'b1;
      tick();
      exp_count++;
      bus.redirect_ready = 1'b0;
      total++; if (bus.mispredict_count !== 16'(exp_count)) begin bad++; $display("FAIL oldest_cnt got=%0d want=%0d", bus.mispredict_count, exp_count); end
      total++; if (bus.redirect_valid !== 1'b0) begin bad++; $display("FAIL oldest_rv_off got=%b want=0", bus.redirect_valid); end
   endtask

   task automatic test_wrap();
      bus.rob_head_idx = 7'd90;
      idle();
      drv(0, 1'b1, 0, 2, 20'h0, 21'h2);
      drv(1, 1'b1, 5, 93, 20'h0, 21'h93);
      sb.push_back('{res: 20'h00021, mp: 20'h00020});
      tick();
      idle();
      e = sb.pop_front();
      total++; if (bus.brupdate_b1_resolve_mask !== e.res) begin bad++; $display("FAIL wrap_res got=%h want=%h", bus.brupdate_b1_resolve_mask, e.res); end
      total++; if (bus.brupdate_b1_mispredict_mask !== e.mp) begin bad++; $display("FAIL wrap_mp got=%h want=%h", bus.brupdate_b1_mispredict_mask, e.mp); end
      tick();
      total++; if (bus.brupdate_b2_rob_idx !== 7'd93) begin bad++; $display("FAIL wrap_b2rob got=%0d want=93", bus.brupdate_b2_rob_idx); end
      tick();
      bus.redirect_ready = 1'b1;
      tick();
      exp_count++;
      bus.redirect_ready = 1'b0;
      total++; if (bus.mispredict_count !== 16'(exp_count)) begin bad++; $display("FAIL wrap_cnt got=%0d want=%0d", bus.mispredict_count, exp_count); end
   endtask

   task automatic test_kill();
      bus.rob_head_idx = 7'd0;
      idle();
      drv(0, 1'b1, 4, 5, 20'h0, 21'h5);
      sb.push_back('{res: 20'h00010, mp: 20'h00010});
      tick();
      idle();
      e = sb.pop_front();
      total++; if (bus.brupdate_b1_mispredict_mask !== e.mp) begin bad++; $display("FAIL kill1_mp got=%h want=%h", bus.brupdate_b1_mispredict_mask, e.mp); end
      drv(0, 1'b0, 8, 6, 20'h0, 21'h6);
      drv(1, 1'b0, 7, 7, 20'h00010, 21'h7);
      sb.push_back('{res: 20'h00100, mp: 20'h0});
      tick();
      idle();
      e = sb.pop_front();
      total++; if (bus.brupdate_b1_resolve_mask !== e.res) begin bad++; $display("FAIL kill_prev_res got=%h want=%h", bus.brupdate_b1_resolve_mask, e.res); end
      drv(0, 1'b1, 2, 8, 20'h0, 21'h8);
      drv(1, 1'b0, 6, 9, 20'h00004, 21'h9);
      sb.push_back('{res: 20'h00004, mp: 20'h00004});
      tick();
      idle();
      e = sb.pop_front();
      total++; if (bus.brupdate_b1_resolve_mask !== e.res) begin bad++; $display("FAIL kill_same_res got=%h want=%h", bus.brupdate_b1_resolve_mask, e.res); end
      total++; if (bus.brupdate_b1_mispredict_mask !== e.mp) begin bad++; $display("FAIL kill_same_mp got=%h want=%h", bus.brupdate_b1_mispredict_mask, e.mp); end
      bus.redirect_ready = 1'b1;
      repeat (6) tick();
      exp_count += 2;
      bus.redirect_ready = 1'b0;
      total++; if (bus.mispredict_count !== 16'(exp_count)) begin bad++; $display("FAIL kill_cnt got=%0d want=%0d", bus.mispredict_count, exp_count); end
      total++; if (bus.redirect_valid !== 1'b0) begin bad++; $display("FAIL kill_rv got=%b want=0", bus.redirect_valid); end
   endtask

   task automatic test_replace();
      bus.rob_head_idx   = 7'd30;
      bus.redirect_ready = 1'b0;
      idle();
      drv(0, 1'b1, 1, 40, 20'h0, 21'h40);
      tick();
      idle();
      repeat (2) tick();
      total++; if (bus.redirect_rob_idx !== 7'd40) begin bad++; $display("FAIL repl_first got=%0d want=40", bus.redirect_rob_idx); end
      drv(0, 1'b1, 2, 35, 20'h0, 21'h35);
      tick();
      idle();
      repeat (2) tick();
      total++; if (bus.redirect_rob_idx !== 7'd35) begin bad++; $display("FAIL repl_older got=%0d want=35", bus.redirect_rob_idx); end
      total++; if (bus.redirect_target_offset !== 21'h35) begin bad++; $display("FAIL repl_off got=%h want=35", bus.redirect_target_offset); end
      drv(0, 1'b1, 3, 50, 20'h0, 21'h50);
      tick();
      idle();
      repeat (2) tick();
      total++; if (bus.redirect_rob_idx !== 7'd35) begin bad++; $display("FAIL repl_younger got=%0d want=35", bus.redirect_rob_idx); end
      drv(0, 1'b1, 4, 35, 20'h0, 21'h99);
      tick();
      idle();
      repeat (2) tick();
      total++; if (bus.redirect_target_offset !== 21'h35) begin bad++; $display("FAIL repl_equal got=%h want=35", bus.redirect_target_offset); end
      total++; if (bus.mispredict_count !== 16'(exp_count)) begin bad++; $display("FAIL repl_nocnt got=%0d want=%0d", bus.mispredict_count, exp_count); end
      bus.redirect_ready = 1'b1;
      tick();
      exp_count++;
      bus.redirect_ready = 1'b0;
      total++; if (bus.mispredict_count !== 16'(exp_count)) begin bad++; $display("FAIL repl_cnt got=%0d want=%0d", bus.mispredict_count, exp_count); end
      total++; if (bus.redirect_valid !== 1'b0) begin bad++; $display("FAIL repl_rv got=%b want=0", bus.redirect_valid); end
   endtask

   task automatic test_back_to_back();
      bus.rob_head_idx   = 7'd30;
      bus.redirect_ready = 1'b0;
      idle();
      drv(0, 1'b1, 1, 40, 20'h0, 21'h1);
      tick();
      idle();
      tick();
      tick();
      drv(0, 1'b1, 2, 33, 20'h0, 21'h2);
      tick();
      idle();
      tick();
      bus.redirect_ready = 1'b1;
      tick();
      exp_count++;
      total++; if (bus.mispredict_count !== 16'(exp_count)) begin bad++; $display("FAIL b2b_cnt1 got=%0d want=%0d", bus.mispredict_count, exp_count); end
      total++; if (bus.redirect_valid !== 1'b1) begin bad++; $display("FAIL b2b_rv got=%b want=1", bus.redirect_valid); end
      total++; if (bus.redirect_rob_idx !== 7'd33) begin bad++; $display("FAIL b2b_rob got=%0d want=33", bus.redirect_rob_idx); end
      tick();
      exp_count++;
      bus.redirect_ready = 1'b0;
      total++; if (bus.mispredict_count !== 16'(exp_count)) begin bad++; $display("FAIL b2b_cnt2 got=%0d want=%0d", bus.mispredict_count, exp_count); end
      total++; if (bus.redirect_valid !== 1'b0) begin bad++; $display("FAIL b2b_rv_off got=%b want=0", bus.redirect_valid); end
   endtask

   task automatic test_async_reset();
      bus.rob_head_idx   = 7'd0;
      bus.redirect_ready = 1'b0;
      idle();
      drv(0, 1'b1, 1, 10, 20'h0, 21'h10);
      tick();
      idle();
      repeat (2) tick();
      total++; if (bus.redirect_valid !== 1'b1) begin bad++; $display("FAIL arst_pre got=%b want=1", bus.redirect_valid); end
      #2;
      reset = 1'b0;
      #1;
      exp_count = 0;
      total++; if (bus.redirect_valid !== 1'b0) begin bad++; $display("FAIL arst_rv got=%b want=0", bus.redirect_valid); end
      total++; if (bus.mispredict_count !== 16'd0) begin bad++; $display("FAIL arst_cnt got=%0d want=0", bus.mispredict_count); end
      @(negedge clock);
      reset = 1'b1;
      tick();
   endtask

   task automatic test_flush();
      bus.rob_head_idx   = 7'd0;
      bus.redirect_ready = 1'b0;
      idle();
      drv(0, 1'b1, 1, 10, 20'h0, 21'h10);
      tick();
      idle();
      repeat (2) tick();
      bus.redirect_ready = 1'b1;
      tick();
      exp_count++;
      bus.redirect_ready = 1'b0;
      drv(0, 1'b1, 2, 11, 20'h0, 21'h11);
      tick();
      idle();
      repeat (2) tick();
      total++; if (bus.redirect_valid !== 1'b1) begin bad++; $display("FAIL flush_pre got=%b want=1", bus.redirect_valid); end
      bus.flush          = 1'b1;
      bus.redirect_ready = 1'b1;
      drv(0, 1'b0, 3, 12, 20'h0, 21'h12);
      tick();
      idle();
      bus.redirect_ready = 1'b0;
      total++; if (bus.redirect_valid !== 1'b0) begin bad++; $display("FAIL flush_rv got=%b want=0", bus.redirect_valid); end
      total++; if (bus.mispredict_count !== 16'(exp_count)) begin bad++; $display("FAIL flush_cnt got=%0d want=%0d", bus.mispredict_count, exp_count); end
      total++; if (bus.brupdate_b1_resolve_mask !== 20'h0) begin bad++; $display("FAIL flush_res got=%h want=0", bus.brupdate_b1_resolve_mask); end
      tick();
      total++; if (bus.redirect_valid !== 1'b0) begin bad++; $display("FAIL flush_idle got=%b want=0", bus.redirect_valid); end
      total++; if (bus.brupdate_b2_mispredict !== 1'b0) begin bad++; $display("FAIL flush_b2 got=%b want=0", bus.brupdate_b2_mispredict); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_resolve();
      test_oldest();
      test_wrap();
      test_kill();
      test_replace();
      test_back_to_back();
      test_async_reset();
      test_flush();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
